wb_scratch_responder: RTL and testbench

Wishbone classic responder (slave) for the 14-bit word-addressed, 32-bit data bus driven by the TT pin-to-wishbone master. It holds a read-only ID word, a transaction counter and a small bank of scratch registers, and inserts programmable wait states before ACK. It is the first bus target in the design and serves as the bring-up and loopback endpoint for the CPU-driven master.

---
 rtl/wb_scratch_responder.sv | 121 ++++++++++++
 tb/tb_wb_scratch_responder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/wb_scratch_responder.sv
// Wishbone classic responder: read-only ID word, 16-bit transfer counter and a small
// bank of byte-writable scratch words, with a fixed number of wait states before ACK.
module wb_scratch_responder #(
    parameter logic [13:0] BASE_ADDR   = 14'h0000,
    parameter int          NWORDS      = 4,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] ID_VALUE    = 32'h7474_0401
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_CYC,
    input  logic        wb_STB,
    input  logic        wb_WE,
    input  logic [13:0] wb_ADR,
    input  logic [31:0] wb_DAT_MOSI,
    input  logic [3:0]  wb_SEL,
    output logic        wb_ACK,
    output logic [31:0] wb_DAT_MISO
);

    typedef enum logic [1:0] {IDLE, WAIT, ACK, DONE} state_t;

    state_t      state;
    logic [2:0]  wait_cnt;
    logic [15:0] txcnt;
    logic [31:0] scratch [NWORDS];

    logic        req_we;
    logic [13:0] req_adr;
    logic [31:0] req_dat;
    logic [3:0]  req_sel;

    logic [13:0] offset;
    logic        hit;
    logic [31:0] rd_word;

    // Offset is compared in 15 bits so a window near the top of the space cannot wrap.
    always_comb begin
        offset = req_adr - BASE_ADDR;
        hit    = (req_adr >= BASE_ADDR) && ({1'b0, offset} < 15'(NWORDS + 2));
    end

    always_comb begin
        rd_word = '0;
        if (hit) begin
            if (offset == 14'd0)
                rd_word = ID_VALUE;
            else if (offset == 14'd1)
                rd_word = {16'h0000, txcnt};
            for (int i = 0; i < NWORDS; i++)
                if (offset == 14'(i + 2))
                    rd_word = scratch[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            txcnt       <= '0;
            wb_ACK      <= 1'b0;
            wb_DAT_MISO <= '0;
            req_we      <= 1'b0;
            req_adr     <= '0;
            req_dat     <= '0;
            req_sel     <= '0;
            for (int i = 0; i < NWORDS; i++)
                scratch[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wb_ACK      <= 1'b0;
                    wb_DAT_MISO <= '0;
                    if (wb_CYC && wb_STB) begin
                        req_we   <= wb_WE;
                        req_adr  <= wb_ADR;
                        req_dat  <= wb_DAT_MOSI;
                        req_sel  <= wb_SEL;
                        wait_cnt <= 3'(WAIT_STATES);
                        // A zero count makes WAIT a single pass-through cycle, keeping latency at WAIT_STATES+1.
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        state       <= ACK;
                        wb_ACK      <= 1'b1;
                        wb_DAT_MISO <= req_we ? 32'h0 : rd_word;
                        txcnt       <= txcnt + 16'd1;
                        if (req_we && hit) begin
                            if (offset == 14'd1)
                                txcnt <= '0;
                            for (int i = 0; i < NWORDS; i++)
                                if (offset == 14'(i + 2))
                                    for (int b = 0; b < 4; b++)
                                        if (req_sel[b])
                                            scratch[i][8*b +: 8] <= req_dat[8*b +: 8];
                        end
                    end else if (!wb_CYC) begin
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                ACK: begin
                    wb_ACK      <= 1'b0;
                    wb_DAT_MISO <= '0;
                    state       <= wb_STB ? DONE : IDLE;
                end
                DONE: begin
                    wb_ACK      <= 1'b0;
                    wb_DAT_MISO <= '0;
                    if (!wb_STB)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_scratch_responder.sv
// Directed bench for wb_scratch_responder: a vector table on a WAIT_STATES=1 instance
// plus hand sequences (held strobe, abort, reset mid-transfer) on a WAIT_STATES=3 instance.
module tb_wb_scratch_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        cyc1, stb1, cyc3, stb3;
    logic        we;
    logic [13:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        ack1, ack3;
    logic [31:0] miso1, miso3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_scratch_responder #(.WAIT_STATES(1)) u1 (
        .clk(clk), .reset(reset), .wb_CYC(cyc1), .wb_STB(stb1), .wb_WE(we),
        .wb_ADR(adr), .wb_DAT_MOSI(dat), .wb_SEL(sel), .wb_ACK(ack1), .wb_DAT_MISO(miso1)
    );

    wb_scratch_responder #(.WAIT_STATES(3)) u3 (
        .clk(clk), .reset(reset), .wb_CYC(cyc3), .wb_STB(stb3), .wb_WE(we),
        .wb_ADR(adr), .wb_DAT_MOSI(dat), .wb_SEL(sel), .wb_ACK(ack3), .wb_DAT_MISO(miso3)
    );

    typedef struct {
        logic        we;
        logic [13:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic get_ack(input int which);
        return (which == 1) ? ack1 : ack3;
    endfunction

    function automatic logic [31:0] get_miso(input int which);
        return (which == 1) ? miso1 : miso3;
    endfunction

    task automatic set_bus(input int which, input logic c, input logic s);
        if (which == 1) begin cyc1 = c; stb1 = s; end
        else            begin cyc3 = c; stb3 = s; end
    endtask

    // One full transfer; lat counts edges from the strobe-sampling edge (0) to ACK high.
    task automatic xfer(input int which, input logic w, input logic [13:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] rdata, output int lat);
        @(negedge clk);
        we = w; adr = a; dat = d; sel = s;
        set_bus(which, 1'b1, 1'b1);
        lat = -1; rdata = '0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (get_ack(which)) begin
                lat = n; rdata = get_miso(which);
                break;
            end
        end
        @(negedge clk);
        set_bus(which, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("ack_one_cycle", {31'h0, get_ack(which)}, 32'h0);
        check("miso_cleared", get_miso(which), 32'h0);
    endtask

    task automatic rd_check(input int which, input string name, input logic [13:0] a,
                            input logic [31:0] exp, input int exp_lat);
        logic [31:0] r;
        int          l;
        xfer(which, 1'b0, a, 32'h0, 4'h0, r, l);
        check({name, "_lat"}, l, exp_lat);
        check(name, r, exp);
    endtask

    task automatic count_acks(input int which, input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (get_ack(which)) n++;
        end
    endtask

    initial begin
        logic [31:0] r;
        int          l, n;

        vecs[0]  = '{1'b0, 14'h000, 32'h0,        4'h0, 1'b1, 32'h7474_0401};
        vecs[1]  = '{1'b0, 14'h001, 32'h0,        4'h0, 1'b1, 32'd1};
        vecs[2]  = '{1'b1, 14'h002, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 14'h002, 32'h0,        4'h0, 1'b1, 32'hDEADBEEF};
        vecs[4]  = '{1'b0, 14'h003, 32'h0,        4'h0, 1'b1, 32'h0};
        vecs[5]  = '{1'b1, 14'h002, 32'h11223344, 4'h5, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 14'h002, 32'h0,        4'h0, 1'b1, 32'hDE22BE44};
        vecs[7]  = '{1'b0, 14'h100, 32'h0,        4'h0, 1'b1, 32'h0};
        vecs[8]  = '{1'b1, 14'h000, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 14'h000, 32'h0,        4'h0, 1'b1, 32'h7474_0401};
        vecs[10] = '{1'b0, 14'h001, 32'h0,        4'h0, 1'b1, 32'd10};
        vecs[11] = '{1'b1, 14'h001, 32'h0000FFFF, 4'hF, 1'b0, 32'h0};
        vecs[12] = '{1'b0, 14'h001, 32'h0,        4'h0, 1'b1, 32'd0};
        vecs[13] = '{1'b1, 14'h005, 32'h12345678, 4'h8, 1'b0, 32'h0};
        vecs[14] = '{1'b0, 14'h005, 32'h0,        4'h0, 1'b1, 32'h12000000};
        vecs[15] = '{1'b0, 14'h006, 32'h0,        4'h0, 1'b1, 32'h0};
        vecs[16] = '{1'b1, 14'h006, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0};
        vecs[17] = '{1'b0, 14'h005, 32'h0,        4'h0, 1'b1, 32'h12000000};
        vecs[18] = '{1'b0, 14'h001, 32'h0,        4'h0, 1'b1, 32'd6};

        reset = 1'b1; cyc1 = 0; stb1 = 0; cyc3 = 0; stb3 = 0;
        we = 0; adr = '0; dat = '0; sel = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ack", {31'h0, ack1}, 32'h0);
        check("reset_miso", miso1, 32'h0);
        @(negedge clk); reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            xfer(1, vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, r, l);
            check($sformatf("vec%0d_lat", i), l, 2);
            if (vecs[i].chk)
                check($sformatf("vec%0d_data", i), r, vecs[i].exp);
        end

        // Strobe held 3 cycles past ACK must yield exactly one pulse.
        @(negedge clk);
        we = 0; adr = 14'h002; sel = 0;
        cyc1 = 1; stb1 = 1;
        count_acks(1, 6, n);
        @(negedge clk); cyc1 = 0; stb1 = 0;
        count_acks(1, 2, l);
        check("held_stb_acks", n + l, 1);
        rd_check(1, "after_held_txcnt", 14'h001, 32'd8, 2);

        rd_check(3, "ws3_id", 14'h000, 32'h7474_0401, 4);

        // CYC dropped so that it is sampled low 2 edges after the strobe edge.
        @(negedge clk);
        we = 1; adr = 14'h004; dat = 32'hA5A5A5A5; sel = 4'hF;
        cyc3 = 1; stb3 = 1;
        @(posedge clk);
        @(negedge clk);
        cyc3 = 0;
        count_acks(3, 4, n);
        @(negedge clk); stb3 = 0;
        count_acks(3, 4, l);
        check("abort_no_ack", n + l, 0);
        rd_check(3, "abort_adr4", 14'h004, 32'h0, 4);
        rd_check(3, "abort_txcnt", 14'h001, 32'd2, 4);

        xfer(3, 1'b1, 14'h002, 32'hCAFEF00D, 4'hF, r, l);
        check("ws3_wr_lat", l, 4);
        rd_check(3, "ws3_rb", 14'h002, 32'hCAFEF00D, 4);

        // Reset arrives while the write to ADR 3 is still waiting.
        @(negedge clk);
        we = 1; adr = 14'h003; dat = 32'h55AA55AA; sel = 4'hF;
        cyc3 = 1; stb3 = 1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_wait_ack", {31'h0, ack3}, 32'h0);
        @(negedge clk);
        reset = 1'b0; cyc3 = 0; stb3 = 0;
        count_acks(3, 6, n);
        check("rst_wait_no_ack", n, 0);
        rd_check(3, "rst_scratch0", 14'h002, 32'h0, 4);
        rd_check(3, "rst_scratch1", 14'h003, 32'h0, 4);
        rd_check(3, "rst_txcnt", 14'h001, 32'd2, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
